// File: rtl/iobus_uart_pkg.sv
// Shared types and constants for the IOBUS UART transmitter.
// Register offsets are word indices within the 16-byte window.
package iobus_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] OFF_TXDATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS   = 2'd1;
    localparam logic [1:0] OFF_CTRL     = 2'd2;
    localparam logic [1:0] OFF_BAUD_DIV = 2'd3;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/iobus_uart_tx_fifo.sv
// Synchronous TX FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: register window, TX FIFO,
// baud counter, shifter and level interrupt.
module iobus_uart_tx
    import iobus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        INTR
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        intr_q, intr_d;
    logic        enable_q, enable_d;
    logic        intr_en_q, intr_en_d;
    logic [15:0] baud_div_q, baud_div_d;
    logic        ovf_q, ovf_d;

    logic          sel;
    logic [1:0]    off;
    logic          wr_txdata, wr_status, wr_ctrl, wr_baud;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          bit_end;
    logic          unused;

    assign sel       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign off       = IOBUS_ADDR[3:2];
    assign wr_txdata = IOBUS_WR && sel && (off == OFF_TXDATA);
    assign wr_status = IOBUS_WR && sel && (off == OFF_STATUS);
    assign wr_ctrl   = IOBUS_WR && sel && (off == OFF_CTRL);
    assign wr_baud   = IOBUS_WR && sel && (off == OFF_BAUD_DIV);
    assign bit_end   = (cnt_q == '0);
    assign TX        = tx_q;
    assign INTR      = intr_q;
    assign unused    = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (IOBUS_OUT[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        enable_d   = enable_q;
        intr_en_d  = intr_en_q;
        baud_div_d = baud_div_q;
        ovf_d      = ovf_q;
        if (wr_ctrl) begin
            enable_d  = IOBUS_OUT[0];
            intr_en_d = IOBUS_OUT[1];
        end
        if (wr_baud) baud_div_d = IOBUS_OUT[15:0];
        if (wr_status && IOBUS_OUT[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
        intr_d = intr_en_q && fifo_empty && (state_q == ST_IDLE);
    end

    // Every bit boundary reloads the counter from BAUD_DIV.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (enable_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    cnt_d    = baud_div_q;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d     = baud_div_q;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = baud_div_q;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (enable_q && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        cnt_d    = baud_div_q;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        IOBUS_IN = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    IOBUS_IN[STAT_BUSY_BIT]  = (state_q != ST_IDLE);
                    IOBUS_IN[STAT_FULL_BIT]  = fifo_full;
                    IOBUS_IN[STAT_EMPTY_BIT] = fifo_empty;
                    IOBUS_IN[STAT_OVF_BIT]   = ovf_q;
                    IOBUS_IN[STAT_COUNT_LSB +: CW] = fifo_count;
                end
                OFF_CTRL:     IOBUS_IN[1:0]  = {intr_en_q, enable_q};
                OFF_BAUD_DIV: IOBUS_IN[15:0] = baud_div_q;
                default:      IOBUS_IN = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            intr_q     <= 1'b0;
            enable_q   <= 1'b1;
            intr_en_q  <= 1'b0;
            baud_div_q <= DEFAULT_DIV;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            intr_q     <= intr_d;
            enable_q   <= enable_d;
            intr_en_q  <= intr_en_d;
            baud_div_q <= baud_div_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Bench for iobus_uart_tx: random bytes checked against an
// expected serial waveform built from the frame format.
module tb_iobus_uart_tx;

    localparam logic [31:0] BASE     = 32'h1100_0100;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_BAUD   = BASE + 32'hC;

    logic        CLK;
    logic        RESET;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        INTR;

    int n_tests;
    int n_fail;
    bit samp_q[$];
    bit exp_q[$];
    bit busy_all;
    bit intr_any;
    logic [7:0] model_q[$];
    bit model_ovf;

    iobus_uart_tx dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .TX         (TX),
        .INTR       (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(posedge CLK);
        #1;
        IOBUS_WR   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        IOBUS_ADDR = a;
        #1;
        chk(tag, IOBUS_IN, exp);
    endtask

    function automatic logic [31:0] exp_status(input int cnt, input bit ovf,
                                               input bit busy);
        logic [31:0] s;
        s = 32'(cnt) << 8;
        s[3] = ovf;
        s[2] = (cnt == 0);
        s[1] = (cnt == 8);
        s[0] = busy;
        return s;
    endfunction

    // Start, 8 data bits LSB first, stop; bits before change_at use w_early.
    task automatic model_frame(input logic [7:0] b, input int w_early,
                               input int w_late, input int change_at);
        bit lvl;
        int w;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      lvl = 1'b0;
            else if (k == 9) lvl = 1'b1;
            else             lvl = b[k-1];
            w = (k < change_at) ? w_early : w_late;
            repeat (w) exp_q.push_back(lvl);
        end
    endtask

    task automatic grab(input string tag, input int n, input int maxwait,
                        input int wr_at, input logic [31:0] wa,
                        input logic [31:0] wd);
        int w;
        bit wrote;
        samp_q.delete();
        busy_all   = 1'b1;
        intr_any   = 1'b0;
        IOBUS_ADDR = A_STATUS;
        w = 0;
        do begin
            @(posedge CLK);
            #1;
            w++;
        end while (TX !== 1'b0 && w < maxwait);
        chk({tag, "_fall"}, {31'd0, TX}, 32'd0);
        if (TX !== 1'b0) return;
        samp_q.push_back(TX);
        busy_all &= IOBUS_IN[0];
        intr_any |= INTR;
        for (int i = 1; i < n; i++) begin
            wrote = 1'b0;
            if (i == wr_at) begin
                IOBUS_ADDR = wa;
                IOBUS_OUT  = wd;
                IOBUS_WR   = 1'b1;
                wrote      = 1'b1;
            end
            @(posedge CLK);
            #1;
            if (wrote) begin
                IOBUS_WR   = 1'b0;
                IOBUS_ADDR = A_STATUS;
                #1;
            end
            samp_q.push_back(TX);
            busy_all &= IOBUS_IN[0];
            intr_any |= INTR;
        end
    endtask

    task automatic cmp_stream(input string tag);
        int mism;
        int first;
        int n;
        mism  = 0;
        first = -1;
        n = (samp_q.size() < exp_q.size()) ? samp_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (samp_q[i] != exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_len"}, samp_q.size(), exp_q.size());
        chk({tag, "_bits"}, mism, 0);
        if (mism != 0) $display("  %s first bad sample %0d", tag, first);
    endtask

    initial begin
        logic [7:0] b;
        int div;
        int k;
        int falls;

        n_tests    = 0;
        n_fail     = 0;
        RESET      = 1'b1;
        IOBUS_ADDR = '0;
        IOBUS_OUT  = '0;
        IOBUS_WR   = 1'b0;
        tick(3);
        RESET = 1'b0;

        chk("tx_rst", {31'd0, TX}, 32'd1);
        chk("intr_rst", {31'd0, INTR}, 32'd0);
        rd_chk("status_rst", A_STATUS, 32'h4);
        rd_chk("ctrl_rst", A_CTRL, 32'h1);
        rd_chk("baud_rst", A_BAUD, 32'd867);
        rd_chk("unmapped_rd", 32'h1100_0200, 32'h0);
        rd_chk("txdata_rd", A_TXDATA, 32'h0);

        // Single 0xA5 frame at BAUD_DIV=3
        bus_wr(A_BAUD, 32'd3);
        rd_chk("baud_wr", A_BAUD, 32'd3);
        bus_wr(A_TXDATA, 32'hA5);
        chk("a5_pre", {31'd0, TX}, 32'd1);
        exp_q.delete();
        model_frame(8'hA5, 4, 4, 10);
        grab("a5", 40, 1, -1, 32'd0, 32'd0);
        cmp_stream("a5");
        chk("a5_busy", {31'd0, busy_all}, 32'd1);
        tick(1);
        rd_chk("a5_idle", A_STATUS, 32'h4);

        // Overflow with transmitter disabled, then burst
        bus_wr(A_CTRL, 32'h0);
        model_q.delete();
        model_ovf = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            bus_wr(A_TXDATA, {24'd0, b});
            if (model_q.size() < 8) model_q.push_back(b);
            else model_ovf = 1'b1;
        end
        rd_chk("ovf_status", A_STATUS,
               exp_status(model_q.size(), model_ovf, 1'b0));
        exp_q.delete();
        foreach (model_q[i]) model_frame(model_q[i], 4, 4, 10);
        bus_wr(A_CTRL, 32'h1);
        grab("burst", 320, 1, -1, 32'd0, 32'd0);
        cmp_stream("burst");
        chk("burst_busy", {31'd0, busy_all}, 32'd1);
        tick(1);
        rd_chk("burst_done", A_STATUS, exp_status(0, model_ovf, 1'b0));
        bus_wr(A_STATUS, 32'h8);
        rd_chk("ovf_clr", A_STATUS, 32'h4);

        // Interrupt behaviour
        bus_wr(A_CTRL, 32'h3);
        tick(1);
        chk("intr_idle", {31'd0, INTR}, 32'd1);
        b = 8'($urandom);
        bus_wr(A_TXDATA, {24'd0, b});
        exp_q.delete();
        model_frame(b, 4, 4, 10);
        grab("intr", 40, 1, -1, 32'd0, 32'd0);
        cmp_stream("intr");
        chk("intr_busy", {31'd0, intr_any}, 32'd0);
        tick(1);
        chk("intr_stop_edge", {31'd0, INTR}, 32'd0);
        tick(1);
        chk("intr_after", {31'd0, INTR}, 32'd1);
        bus_wr(A_CTRL, 32'h1);
        tick(1);
        chk("intr_off", {31'd0, INTR}, 32'd0);

        // BAUD_DIV 3->7 written mid data bit 2
        b = 8'($urandom);
        bus_wr(A_TXDATA, {24'd0, b});
        exp_q.delete();
        model_frame(b, 4, 8, 4);
        grab("bdchg", 64, 1, 14, A_BAUD, 32'd7);
        cmp_stream("bdchg");
        tick(1);
        rd_chk("bdchg_idle", A_STATUS, 32'h4);

        // Random divisors and byte counts
        for (int r = 0; r < 4; r++) begin
            div = $urandom_range(0, 5);
            k   = $urandom_range(1, 4);
            bus_wr(A_BAUD, 32'(div));
            bus_wr(A_CTRL, 32'h0);
            exp_q.delete();
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                bus_wr(A_TXDATA, {24'd0, b});
                model_frame(b, div + 1, div + 1, 10);
            end
            rd_chk("rnd_queued", A_STATUS, exp_status(k, 1'b0, 1'b0));
            bus_wr(A_CTRL, 32'h1);
            grab("rnd", k * 10 * (div + 1), 1, -1, 32'd0, 32'd0);
            cmp_stream("rnd");
            tick(1);
            rd_chk("rnd_idle", A_STATUS, 32'h4);
        end

        // Reset during data bit 4 with bytes still queued
        bus_wr(A_BAUD, 32'd3);
        bus_wr(A_CTRL, 32'h0);
        exp_q.delete();
        for (int j = 0; j < 3; j++) begin
            b = 8'($urandom);
            bus_wr(A_TXDATA, {24'd0, b});
            if (j == 0) model_frame(b, 4, 4, 10);
        end
        while (exp_q.size() > 21) void'(exp_q.pop_back());
        bus_wr(A_CTRL, 32'h1);
        grab("pre_rst", 21, 1, -1, 32'd0, 32'd0);
        cmp_stream("pre_rst");
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        chk("rst_tx", {31'd0, TX}, 32'd1);
        chk("rst_intr", {31'd0, INTR}, 32'd0);
        rd_chk("rst_status", A_STATUS, 32'h4);
        rd_chk("rst_baud", A_BAUD, 32'd867);
        rd_chk("rst_ctrl", A_CTRL, 32'h1);
        falls = 0;
        repeat (60) begin
            tick(1);
            if (TX !== 1'b1) falls++;
        end
        chk("rst_quiet", falls, 0);

        // Writes just past the window must not alias
        bus_wr(BASE + 32'h10, 32'h55);
        bus_wr(BASE + 32'h14, 32'hFF);
        bus_wr(BASE + 32'h18, 32'h2);
        bus_wr(BASE + 32'h1C, 32'h5);
        rd_chk("alias_rd", BASE + 32'h18, 32'h0);
        rd_chk("alias_status", A_STATUS, 32'h4);
        rd_chk("alias_ctrl", A_CTRL, 32'h1);
        rd_chk("alias_baud", A_BAUD, 32'd867);
        falls = 0;
        repeat (20) begin
            tick(1);
            if (TX !== 1'b1) falls++;
        end
        chk("alias_quiet", falls, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
